softmax_norm: RTL and testbench



---
 rtl/softmax_pkg.sv | 19 +
 rtl/softmax_norm_seq_div.sv | 84 ++++++++
 rtl/softmax_norm.sv | 161 ++++++++++++++++
 tb/tb_softmax_norm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax normalisation stage.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DIVIDE  = 2'd2,
    OUTPUT  = 2'd3
  } norm_state_t;

  localparam int unsigned FIXED_PNT_DEF = 8;
  localparam int unsigned ONE           = 1 << FIXED_PNT_DEF;

  // Sum of VEC_LEN non-negative words cannot exceed this width.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned vec_len);
    return data_w + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/softmax_norm_seq_div.sv
// Restoring divider, one quotient bit per cycle; the first step runs in the start cycle.
module seq_div #(
  parameter int unsigned NUM_W = 24,
  parameter int unsigned DEN_W = 19,
  parameter int unsigned QUO_W = 9,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(QUO_W) + 1;

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [QUO_W-1:0] low_q, low_d;
  logic [QUO_W-1:0] quo_q, quo_d;

  logic             run;
  logic [DEN_W-1:0] rem_in;
  logic [QUO_W-1:0] low_in;
  logic [QUO_W-1:0] quo_in;
  logic [CNT_W-1:0] cnt_in;
  logic [DEN_W:0]   trial;
  logic             qbit;
  logic [QUO_W-1:0] quo_next;

  // The quotient never exceeds QUO_W bits because num <= den << (QUO_W-1),
  // so the upper numerator bits seed the remainder directly.
  always_comb begin
    run      = start | active_q;
    rem_in   = start ? DEN_W'(num[NUM_W-1:QUO_W]) : rem_q;
    low_in   = start ? num[QUO_W-1:0] : low_q;
    quo_in   = start ? '0 : quo_q;
    cnt_in   = start ? '0 : cnt_q;
    trial    = {rem_in, low_in[QUO_W-1]};
    qbit     = 1'b0;
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    low_d    = low_q;
    quo_d    = quo_q;
    done     = 1'b0;

    if (trial >= {1'b0, den}) begin
      qbit = 1'b1;
    end
    quo_next = {quo_in[QUO_W-2:0], qbit};

    if (run) begin
      rem_d    = qbit ? DEN_W'(trial - {1'b0, den}) : trial[DEN_W-1:0];
      low_d    = {low_in[QUO_W-2:0], 1'b0};
      quo_d    = quo_next;
      cnt_d    = cnt_in + CNT_W'(1);
      done     = (cnt_in == CNT_W'(QUO_W - 1));
      active_d = !done;
    end

    quotient = (den == '0) ? '0 : OUT_W'(quo_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      low_q    <= '0;
      quo_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      low_q    <= low_d;
      quo_q    <= quo_d;
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers a vector, sums it, then emits each element / sum.
module softmax_norm
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIXED_PNT  = 8,
  parameter int unsigned VEC_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, VEC_LEN);
  localparam int unsigned IDX_W = $clog2(VEC_LEN);
  localparam int unsigned NUM_W = DATA_WIDTH + FIXED_PNT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  norm_state_t state_q, state_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  div_start_q, div_start_d;

  logic [DATA_WIDTH-1:0] vec_buf_q [VEC_LEN];
  logic                  buf_we;
  logic [IDX_W-1:0]      buf_widx;

  logic                  accept;
  logic [DATA_WIDTH-1:0] clamped;
  logic                  div_done;
  logic [DATA_WIDTH-1:0] div_quot;
  logic [NUM_W-1:0]      div_num;

  assign accept  = in_valid && in_ready_q;
  assign clamped = in_data[DATA_WIDTH-1] ? '0 : in_data;
  assign div_num = {vec_buf_q[rd_idx_q], {FIXED_PNT{1'b0}}};

  seq_div #(
    .NUM_W (NUM_W),
    .DEN_W (ACC_W),
    .QUO_W (FIXED_PNT + 1),
    .OUT_W (DATA_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_q),
    .num      (div_num),
    .den      (acc_q),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    buf_we     = 1'b0;
    buf_widx   = wr_idx_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          buf_we   = 1'b1;
          buf_widx = '0;
          acc_d    = ACC_W'(clamped);
          wr_idx_d = IDX_W'(1);
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          buf_we   = 1'b1;
          acc_d    = acc_q + ACC_W'(clamped);
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (div_done) begin
          out_data_d = div_quot;
          state_d    = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            state_d  = DIVIDE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    in_ready_d  = (state_d == IDLE) || (state_d == COLLECT);
    out_valid_d = (state_d == OUTPUT);
    out_last_d  = (state_d == OUTPUT) && (rd_idx_d == LAST_IDX);
    busy_d      = (state_d != IDLE);
    div_start_d = (state_d == DIVIDE) && (state_q != DIVIDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      div_start_q <= div_start_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      vec_buf_q[buf_widx] <= clamped;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm with hand-computed normalised outputs.
module tb_softmax_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] vec     [8];
  logic [15:0] rx_data [8];
  logic        rx_last [8];
  int          rx_gap  [8];
  bit          rx_to;

  always #5 clk = ~clk;

  softmax_norm #(.DATA_WIDTH(16), .FIXED_PNT(8), .VEC_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Drives vec[] back to back; returns just after the edge accepting the last element.
  task automatic send_vec();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vec[i];
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
  endtask

  // Collects n outputs with out_ready high; rx_gap[k] counts negedges since the previous handshake.
  task automatic recv(input int n);
    int cnt;
    int w;
    rx_to = 1'b0;
    cnt   = 0;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        cnt++;
        w++;
      end while (!out_valid && w < 40);
      if (!out_valid) begin
        rx_to = 1'b1;
        break;
      end
      rx_data[k] = out_data;
      rx_last[k] = out_last;
      rx_gap[k]  = cnt;
      cnt        = 0;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 8; i++) vec[i] = 16'h0100;
    out_ready = 1'b1;
    send_vec();
    recv(8);
    total++; if (rx_to) begin bad++; $display("FAIL uniform_timeout got=1 want=0"); end
    total++; if (rx_gap[0] != 10) begin bad++; $display("FAIL uniform_latency got=%0d want=10", rx_gap[0]); end
    for (int k = 0; k < 8; k++) begin
      total++; if (rx_data[k] !== 16'h0020) begin bad++; $display("FAIL uniform_data[%0d] got=%h want=0020", k, rx_data[k]); end
      total++; if (rx_last[k] !== (k == 7)) begin bad++; $display("FAIL uniform_last[%0d] got=%b want=%b", k, rx_last[k], k == 7); end
      if (k > 0) begin
        total++; if (rx_gap[k] != 10) begin bad++; $display("FAIL uniform_spacing[%0d] got=%0d want=10", k, rx_gap[k]); end
      end
    end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL turnaround_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL turnaround_busy got=%b want=0", busy); end
  endtask

  task automatic test_single_peak();
    vec[0] = 16'h0200;
    for (int i = 1; i < 8; i++) vec[i] = 16'h0000;
    send_vec();
    recv(8);
    total++; if (rx_to) begin bad++; $display("FAIL peak_timeout got=1 want=0"); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (rx_data[k] !== ((k == 0) ? 16'h0100 : 16'h0000)) begin
        bad++; $display("FAIL peak_data[%0d] got=%h want=%h", k, rx_data[k], (k == 0) ? 16'h0100 : 16'h0000);
      end
    end
  endtask

  task automatic test_mixed();
    int s;
    vec[0] = 16'h0100;
    vec[1] = 16'h0200;
    for (int i = 2; i < 8; i++) vec[i] = 16'h0100;
    send_vec();
    recv(8);
    total++; if (rx_to) begin bad++; $display("FAIL mixed_timeout got=1 want=0"); end
    s = 0;
    for (int k = 0; k < 8; k++) begin
      s += int'(rx_data[k]);
      total++;
      if (rx_data[k] !== ((k == 1) ? 16'h0038 : 16'h001C)) begin
        bad++; $display("FAIL mixed_data[%0d] got=%h want=%h", k, rx_data[k], (k == 1) ? 16'h0038 : 16'h001C);
      end
    end
    total++; if (s > 256) begin bad++; $display("FAIL mixed_sum got=%0d want<=256", s); end
  endtask

  task automatic test_zero_and_clamp();
    for (int i = 0; i < 8; i++) vec[i] = 16'h0000;
    send_vec();
    recv(8);
    total++; if (rx_to) begin bad++; $display("FAIL zero_timeout got=1 want=0"); end
    total++; if (rx_gap[0] != 10) begin bad++; $display("FAIL zero_latency got=%0d want=10", rx_gap[0]); end
    for (int k = 0; k < 8; k++) begin
      total++; if (rx_data[k] !== 16'h0000) begin bad++; $display("FAIL zero_data[%0d] got=%h want=0000", k, rx_data[k]); end
    end
    vec[0] = 16'hFF00;
    vec[1] = 16'h0100;
    for (int i = 2; i < 8; i++) vec[i] = 16'h0000;
    send_vec();
    recv(8);
    total++; if (rx_to) begin bad++; $display("FAIL clamp_timeout got=1 want=0"); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (rx_data[k] !== ((k == 1) ? 16'h0100 : 16'h0000)) begin
        bad++; $display("FAIL clamp_data[%0d] got=%h want=%h", k, rx_data[k], (k == 1) ? 16'h0100 : 16'h0000);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    for (int i = 0; i < 8; i++) vec[i] = 16'h0100;
    send_vec();
    out_ready = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
      in_valid = ~in_valid;
      in_data  = 16'h7000;
    end while (!out_valid && w < 40);
    total++; if (w != 10) begin bad++; $display("FAIL bp_latency got=%0d want=10", w); end
    total++; if (out_data !== 16'h0020) begin bad++; $display("FAIL bp_first_data got=%h want=0020", out_data); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0020 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=v%b d%h l%b r%b want=v1 d0020 l0 r0", i, out_valid, out_data, out_last, in_ready);
      end
      in_valid = ~in_valid;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    recv(7);
    total++; if (rx_to) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
    for (int k = 0; k < 7; k++) begin
      total++; if (rx_data[k] !== 16'h0020) begin bad++; $display("FAIL bp_data[%0d] got=%h want=0020", k, rx_data[k]); end
    end
    total++; if (rx_last[6] !== 1'b1) begin bad++; $display("FAIL bp_last got=%b want=1", rx_last[6]); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) vec[i] = 16'h0100;
    send_vec();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    rst = 1'b0;
    vec[0] = 16'h0100;
    vec[1] = 16'h0300;
    for (int i = 2; i < 8; i++) vec[i] = 16'h0000;
    send_vec();
    recv(8);
    total++; if (rx_to) begin bad++; $display("FAIL midrst_timeout got=1 want=0"); end
    for (int k = 0; k < 8; k++) begin
      logic [15:0] exp_d;
      exp_d = (k == 0) ? 16'h0040 : (k == 1) ? 16'h00C0 : 16'h0000;
      total++; if (rx_data[k] !== exp_d) begin bad++; $display("FAIL midrst_data[%0d] got=%h want=%h", k, rx_data[k], exp_d); end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_single_peak();
    test_mixed();
    test_zero_and_clamp();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
